sm_warp_scheduler: RTL and testbench
====================================

// Module: sm_warp_scheduler
// PURPOSE
//   Read side of the per-warp instruction buffers. Each cycle it picks one warp whose buffer has data,
//   whose scoreboard is clear and which is ACTIVE, and drives the one-hot pop to the buffers.
//   Round-robin fairness; per-warp lifecycle FSM (IDLE/ACTIVE/BARRIER) with CTA-wide barrier release.
//   Sits between sm_inst_buffer (pop side) and the operand-collect/issue stage.
// PARAMETERS
//   WARP_NUM    `NUM_WARP    number of warps (tests use 8)
//   WID_WIDTH   `DEPTH_WARP  warp id width, log2(WARP_NUM) (tests use 3)
//   CNT_WIDTH   32           width of performance counters
// PORTS
//   clk                     in   1          system clock
//   rst_n                   in   1          asynchronous active-low reset
//   inst_buffer_has_data_i  in   WARP_NUM   per-warp buffer non-empty
//   scoreboard_ready_i      in   WARP_NUM   per-warp head instruction has no hazard
//   issue_ready_i           in   1          downstream issue stage can accept this cycle
//   warp_start_i            in   WARP_NUM   per-warp launch pulse
//   warp_end_valid_i        in   1          warp exit event
//   warp_end_wid_i          in   WID_WIDTH  warp id of exit
//   bar_req_valid_i         in   1          warp reached barrier
//   bar_req_wid_i           in   WID_WIDTH  warp id at barrier
//   warp_to_issue_oh_o      out  WARP_NUM   one-hot pop to instruction buffers (comb)
//   issue_valid_o           out  1          = |warp_to_issue_oh_o
//   issue_wid_o             out  WID_WIDTH  binary id of selected warp (0 when none)
//   warp_active_o           out  WARP_NUM   per-warp state != IDLE
//   all_idle_o              out  1          every warp IDLE
//   issue_cnt_o             out  CNT_WIDTH  instructions issued
//   stall_cnt_o             out  CNT_WIDTH  cycles with >=1 ACTIVE warp and no issue
// BEHAVIOUR
//   Reset: all warps IDLE, rr_ptr=0, counters 0 -> oh=0, issue_valid_o=0, issue_wid_o=0,
//     warp_active_o=0, all_idle_o=1.
//   Eligibility (comb): elig[w] = has_data[w] & scoreboard_ready[w] & (state[w]==ACTIVE).
//   Select (comb, zero latency): if issue_ready_i, first elig warp scanning rr_ptr, rr_ptr+1, ... mod
//     WARP_NUM; else none. Output always one-hot or zero; pop and data consume in same cycle.
//   rr_ptr: on issue, rr_ptr <= (sel+1) mod WARP_NUM (wraps WARP_NUM-1 -> 0); else held.
//   Warp FSM, per warp w, updated on clk:
//     IDLE    -> ACTIVE  on warp_start_i[w]; start to non-IDLE warp ignored.
//     ACTIVE  -> IDLE    on warp_end for w (end wins over bar_req for same warp same cycle).
//     ACTIVE  -> BARRIER on bar_req for w.
//     BARRIER -> ACTIVE  on release; BARRIER -> IDLE on warp_end for w.
//   Release (comb from current states): no warp ACTIVE and >=1 warp in BARRIER; all BARRIER warps
//     become ACTIVE next cycle. End of last ACTIVE warp releases the others one cycle after it goes IDLE.
//   bar_req/end for IDLE warp ignored. A warp entering BARRIER is still selectable in that same cycle
//     (state is registered); the issue stage must not send further instructions of it before the bar.
//   issue_cnt_o +1 per issue; stall_cnt_o +1 when (|warp_active-in-ACTIVE) & ~issue_valid_o.
//     Both wrap modulo 2^CNT_WIDTH.
//   Reset mid-operation: all state cleared asynchronously; pending barrier discarded.
// TESTING
//   1 start=8'h05, has_data=sb_ready=8'hFF, issue_ready=1 -> oh 01,04,01,04...; issue_cnt=4 after 4 cyc.
//   2 as 1 then issue_ready=0 3 cyc -> oh=0, stall_cnt+3, next issue resumes at warp after last issued.
//   3 start=8'h0F, sb_ready=8'hFD -> oh 01,04,08,01 (warp1 skipped); sb_ready[1]=1 -> warp1 served next turn.
//   4 warps 0,1 active; bar wid0 -> only 02 issued; bar wid1 -> next cycle no issue, following cycle both ACTIVE, oh resumes 01.
//   5 warps 0,1 active; bar wid0, then end wid1 -> warp1 IDLE, warp0 ACTIVE 1 cyc later; end wid0 -> all_idle=1.
//   6 only warps 7 and 0 eligible, last issued 7 -> oh=8'h01 (wrap); rst_n low mid-barrier -> all IDLE, counters 0.

Source files
------------

// File: rtl/sm_warp_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sm_warp_scheduler
// Brief    : Round-robin warp selector with per-warp IDLE/ACTIVE/BARRIER FSM
//            and CTA-wide barrier release; drives one-hot pops to inst buffers.
// Revision : 1.0 - initial release
// ============================================================================
module sm_warp_scheduler #(
  parameter int WARP_NUM  = 8,
  parameter int WID_WIDTH = 3,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WARP_NUM-1:0]  inst_buffer_has_data_i,
  input  logic [WARP_NUM-1:0]  scoreboard_ready_i,
  input  logic                 issue_ready_i,
  input  logic [WARP_NUM-1:0]  warp_start_i,
  input  logic                 warp_end_valid_i,
  input  logic [WID_WIDTH-1:0] warp_end_wid_i,
  input  logic                 bar_req_valid_i,
  input  logic [WID_WIDTH-1:0] bar_req_wid_i,
  output logic [WARP_NUM-1:0]  warp_to_issue_oh_o,
  output logic                 issue_valid_o,
  output logic [WID_WIDTH-1:0] issue_wid_o,
  output logic [WARP_NUM-1:0]  warp_active_o,
  output logic                 all_idle_o,
  output logic [CNT_WIDTH-1:0] issue_cnt_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o
);

  localparam int                   c_scan_w   = WID_WIDTH + 1;
  localparam logic [WID_WIDTH-1:0] c_last_wid = WID_WIDTH'(WARP_NUM - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ACTIVE  = 2'b01,
    ST_BARRIER = 2'b10
  } warp_state_e;

  logic [WARP_NUM-1:0]  w_is_active;
  logic [WARP_NUM-1:0]  w_is_barrier;
  logic [WARP_NUM-1:0]  w_elig;
  logic                 w_release;
  logic [WID_WIDTH-1:0] r_rr_ptr;
  logic [WID_WIDTH-1:0] w_sel;
  logic                 w_found;
  logic [c_scan_w-1:0]  w_scan;
  logic [CNT_WIDTH-1:0] r_issue_cnt;
  logic [CNT_WIDTH-1:0] r_stall_cnt;

  // Barrier opens once nobody is left running but someone is waiting.
  assign w_release = ~(|w_is_active) & (|w_is_barrier);

  generate
    for (genvar g = 0; g < WARP_NUM; g++) begin : g_warp
      warp_state_e r_state;
      warp_state_e w_next;
      logic        w_end_hit;
      logic        w_bar_hit;

      assign w_end_hit = warp_end_valid_i & (warp_end_wid_i == WID_WIDTH'(g));
      assign w_bar_hit = bar_req_valid_i  & (bar_req_wid_i  == WID_WIDTH'(g));

      always_comb begin
        w_next = r_state;
        case (r_state)
          ST_IDLE:    if (warp_start_i[g]) w_next = ST_ACTIVE;
          ST_ACTIVE: begin
            if (w_end_hit)      w_next = ST_IDLE;
            else if (w_bar_hit) w_next = ST_BARRIER;
          end
          ST_BARRIER: begin
            if (w_end_hit)      w_next = ST_IDLE;
            else if (w_release) w_next = ST_ACTIVE;
          end
          default:              w_next = ST_IDLE;
        endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
      end

      assign w_is_active[g]   = (r_state == ST_ACTIVE);
      assign w_is_barrier[g]  = (r_state == ST_BARRIER);
      assign warp_active_o[g] = (r_state != ST_IDLE);
      assign w_elig[g] = inst_buffer_has_data_i[g] & scoreboard_ready_i[g] & w_is_active[g];
    end
  endgenerate

  // Scan starting at rr_ptr, wrapping modulo WARP_NUM; first eligible wins.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_scan  = '0;
    for (int i = 0; i < WARP_NUM; i++) begin
      w_scan = {1'b0, r_rr_ptr} + c_scan_w'(i);
      if (w_scan >= c_scan_w'(WARP_NUM)) w_scan = w_scan - c_scan_w'(WARP_NUM);
      if (!w_found && issue_ready_i && w_elig[w_scan[WID_WIDTH-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_scan[WID_WIDTH-1:0];
      end
    end
  end

  assign warp_to_issue_oh_o = w_found ? (WARP_NUM'(1) << w_sel) : '0;
  assign issue_valid_o      = w_found;
  assign issue_wid_o        = w_found ? w_sel : '0;
  assign all_idle_o         = ~(|warp_active_o);
  assign issue_cnt_o        = r_issue_cnt;
  assign stall_cnt_o        = r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_found) begin
        r_rr_ptr    <= (w_sel == c_last_wid) ? '0 : w_sel + 1'b1;
        r_issue_cnt <= r_issue_cnt + 1'b1;
      end else if (|w_is_active) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sm_warp_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm_warp_scheduler
// Brief    : Directed scoreboard bench: stimulus queues expected pops, a
//            negedge monitor pops and compares against the DUT select.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sm_warp_scheduler;

  localparam int WN = 8;
  localparam int WW = 3;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [WN-1:0] has_data, sb_ready, start;
  logic          issue_ready, end_valid, bar_valid;
  logic [WW-1:0] end_wid, bar_wid;
  logic [WN-1:0] oh, active;
  logic          ivalid, all_idle;
  logic [WW-1:0] iwid;
  logic [CW-1:0] icnt, scnt;

  int checks   = 0;
  int failures = 0;
  logic [WN-1:0] exp_q[$];

  sm_warp_scheduler #(.WARP_NUM(WN), .WID_WIDTH(WW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_buffer_has_data_i(has_data), .scoreboard_ready_i(sb_ready),
    .issue_ready_i(issue_ready), .warp_start_i(start),
    .warp_end_valid_i(end_valid), .warp_end_wid_i(end_wid),
    .bar_req_valid_i(bar_valid), .bar_req_wid_i(bar_wid),
    .warp_to_issue_oh_o(oh), .issue_valid_o(ivalid), .issue_wid_o(iwid),
    .warp_active_o(active), .all_idle_o(all_idle),
    .issue_cnt_o(icnt), .stall_cnt_o(scnt)
  );

  always #5 clk = ~clk;

  // Monitor: one expected pop per queued cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [WN-1:0] e;
      logic [WW-1:0] ew;
      e  = exp_q.pop_front();
      ew = '0;
      for (int i = 0; i < WN; i++) if (e[i]) ew = WW'(i);
      checks++;
      if (oh !== e || ivalid !== (|e) || iwid !== ew) begin
        failures++;
        $display("FAIL sel: oh=%h valid=%b wid=%0d, required oh=%h valid=%b wid=%0d",
                 oh, ivalid, iwid, e, |e, ew);
      end
    end
  end

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Queue the expected pop for the current cycle, then advance one clock.
  task automatic step(input logic [WN-1:0] exp_oh);
    exp_q.push_back(exp_oh);
    @(posedge clk); #1;
  endtask

  task automatic clear_pulses();
    start = '0; end_valid = 1'b0; bar_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_pulses();
    has_data = '0; sb_ready = '0; issue_ready = 1'b0;
    end_wid = '0; bar_wid = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_oh", CW'(oh), 0);
    chk("rst_idle", CW'(all_idle), 1);
    chk("rst_active", CW'(active), 0);
    chk("rst_cnts", icnt | scnt, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    do_reset();

    // Two warps active, full readiness: alternate 0/2.
    has_data = '1; sb_ready = '1; issue_ready = 1'b1; start = 8'h05;
    step(8'h00); clear_pulses();
    step(8'h01); step(8'h04); step(8'h01); step(8'h04);
    chk("t1_issue_cnt", icnt, 4);
    chk("t1_stall_cnt", scnt, 0);
    // Backpressure: three stalls, then resume after warp 2.
    issue_ready = 1'b0;
    step(8'h00); step(8'h00); step(8'h00);
    chk("t2_stall_cnt", scnt, 3);
    issue_ready = 1'b1;
    step(8'h01); step(8'h04);
    chk("t2_issue_cnt", icnt, 6);

    // Scoreboard hazard on warp 1 skips it until cleared.
    do_reset();
    has_data = '1; sb_ready = 8'hFD; issue_ready = 1'b1; start = 8'h0F;
    step(8'h00); clear_pulses();
    step(8'h01); step(8'h04); step(8'h08); step(8'h01);
    sb_ready = '1;
    step(8'h02); step(8'h04);

    // Barrier across warps 0 and 1.
    do_reset();
    has_data = '1; sb_ready = '1; issue_ready = 1'b1; start = 8'h03;
    step(8'h00); clear_pulses();
    bar_valid = 1'b1; bar_wid = 3'd0;
    step(8'h01); clear_pulses();
    step(8'h02); step(8'h02);
    bar_valid = 1'b1; bar_wid = 3'd1;
    step(8'h02); clear_pulses();
    chk("t4_both_bar_active", CW'(active), 8'h03);
    step(8'h00);
    step(8'h01); step(8'h02);
    chk("t4_stall_cnt", scnt, 0);
    chk("t4_issue_cnt", icnt, 6);

    // Last active warp exits: waiting warp released a cycle later.
    do_reset();
    has_data = '1; sb_ready = '1; issue_ready = 1'b0; start = 8'h03;
    step(8'h00); clear_pulses();
    bar_valid = 1'b1; bar_wid = 3'd0;
    step(8'h00); clear_pulses();
    end_valid = 1'b1; end_wid = 3'd1;
    step(8'h00); clear_pulses();
    chk("t5_active_after_end", CW'(active), 8'h01);
    issue_ready = 1'b1;
    step(8'h00);
    step(8'h01);
    issue_ready = 1'b0; end_valid = 1'b1; end_wid = 3'd0;
    step(8'h00); clear_pulses();
    chk("t5_all_idle", CW'(all_idle), 1);
    chk("t5_stall_cnt", scnt, 3);
    chk("t5_issue_cnt", icnt, 1);

    // Wrap from warp 7 to warp 0, then async reset while warp 0 waits at a barrier.
    do_reset();
    has_data = '1; sb_ready = '1; issue_ready = 1'b1; start = 8'h81;
    step(8'h00); clear_pulses();
    step(8'h01); step(8'h80); step(8'h01);
    bar_valid = 1'b1; bar_wid = 3'd0;
    step(8'h80); clear_pulses();
    step(8'h80);
    rst_n = 1'b0;
    #2;
    chk("t6_rst_active", CW'(active), 0);
    chk("t6_rst_idle", CW'(all_idle), 1);
    chk("t6_rst_issue_cnt", icnt, 0);
    chk("t6_rst_stall_cnt", scnt, 0);
    chk("t6_rst_oh", CW'(oh), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    step(8'h00);
    chk("t6_no_stale_barrier", CW'(active), 0);

    begin
      int budget = 0;
      while (exp_q.size() > 0 && budget < 10) begin
        @(posedge clk); budget++;
      end
      chk("scoreboard_drained", CW'(exp_q.size()), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
